// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file.
package regfile_pkg;

  // Clear engine states: idle, or sweeping one entry per cycle.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clrState_e;

  // Address width for a given depth; never narrower than one bit.
  function automatic int addrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/reg_nbit.sv
// WIDTH-bit storage register: async active-low reset, sync clear, load enable.
module reg_nbit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear wins over load so a sweep can never be overridden by a write.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_param.sv
// DEPTH x WIDTH register file: two registered read ports with write-first
// bypass, one write port, optional hardwired-zero entry 0, and a clear engine
// that zeroes one entry per cycle.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter bit ZERO_REG = 1'b1,
  parameter int AW       = addrWidth(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr1,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             clr_done
);

  clrState_e        state;
  clrState_e        stateNext;
  logic [AW-1:0]    cnt;
  logic [AW-1:0]    cntNext;
  logic             doneNext;
  logic             sweeping;

  logic [DEPTH-1:0] entryWr;
  logic [DEPTH-1:0] entryClr;
  logic [WIDTH-1:0] regQ      [DEPTH];
  logic [WIDTH-1:0] entryNext [DEPTH];
  logic [WIDTH-1:0] rdNext1;
  logic [WIDTH-1:0] rdNext2;

  assign sweeping = (state == SWEEP);
  assign clr_busy = sweeping;

  // Per-entry write/clear decode and the value each entry holds after the edge.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    entryWr  = '0;
    entryClr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entryWr[i]   = we && !sweeping && (waddr == AW'(i)) && !(ZERO_REG && (i == 0));
      entryClr[i]  = sweeping && (cnt == AW'(i)) && !(ZERO_REG && (i == 0));
      entryNext[i] = entryClr[i] ? '0 : (entryWr[i] ? wdata : regQ[i]);
    end
  end

  // Read muxes over post-edge values; addresses past DEPTH match nothing -> 0.
  always_comb begin
    rdNext1 = '0;
    rdNext2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr1 == AW'(i)) rdNext1 = entryNext[i];
      if (raddr2 == AW'(i)) rdNext2 = entryNext[i];
    end
  end

  // Storage: entry 0 is a constant when hardwired to zero.
  // NOTE: the entries are real flops with reset, not a RAM macro, because
  // the file must read back as all zeros immediately after reset.
  for (genvar i = 0; i < DEPTH; i++) begin : gEntry
    if (ZERO_REG && (i == 0)) begin : gZero
      assign regQ[i] = '0;
    end else begin : gReg
      reg_nbit #(.WIDTH(WIDTH)) uReg (
        .clk   (clk),
        .reset (reset),
        .en    (entryWr[i]),
        .clr   (entryClr[i]),
        .d     (wdata),
        .q     (regQ[i])
      );
    end
  end

  // Registered read ports.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata1 <= '0;
      rdata2 <= '0;
    end else begin
      rdata1 <= rdNext1;
      rdata2 <= rdNext2;
    end
  end

  // Clear engine next-state: requests are only accepted in IDLE, and the
  // sweep ends on a terminal compare rather than counter overflow so that
  // non-power-of-two depths stop at the last real entry.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    doneNext  = 1'b0;
    unique case (state)
      IDLE: begin
        if (clr_req) begin
          stateNext = SWEEP;
          cntNext   = '0;
        end
      end
      SWEEP: begin
        if (cnt == AW'(DEPTH - 1)) begin
          stateNext = IDLE;
          cntNext   = '0;
          doneNext  = 1'b1;
        end else begin
          cntNext = cnt + AW'(1);
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  // Clear engine state register and one-cycle completion pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      clr_done <= doneNext;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default build (8 entries, zero reg),
// a no-zero-reg build, and a 5-entry build driven with shared stimulus.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [2:0]  waddr;
  logic [31:0] wdata;
  logic [2:0]  raddr1;
  logic [2:0]  raddr2;
  logic        clrReq;

  logic [31:0] rd1A, rd2A, rd1B, rd2B, rd1C, rd2C;
  logic        busyA, doneA, busyB, doneB, busyC, doneC;

  int passCount  = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  // Default build: DEPTH=8, ZERO_REG=1.
  regfile_param dutA (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1A), .rdata2(rd2A),
    .clr_req(clrReq), .clr_busy(busyA), .clr_done(doneA)
  );

  // Entry 0 is ordinary storage.
  regfile_param #(.ZERO_REG(1'b0)) dutB (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1B), .rdata2(rd2B),
    .clr_req(clrReq), .clr_busy(busyB), .clr_done(doneB)
  );

  // Non-power-of-two depth, still 3 address bits.
  regfile_param #(.DEPTH(5)) dutC (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1C), .rdata2(rd2C),
    .clr_req(clrReq), .clr_busy(busyC), .clr_done(doneC)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic writeReg(input logic [2:0] addr, input logic [31:0] data);
    we    = 1'b1;
    waddr = addr;
    wdata = data;
    step();
    we    = 1'b0;
  endtask

  initial begin
    reset  = 1'b0;
    we     = 1'b0;
    waddr  = '0;
    wdata  = '0;
    raddr1 = '0;
    raddr2 = '0;
    clrReq = 1'b0;

    // Reset state.
    step();
    step();
    check("rst_rd1", rd1A, 32'h0);
    check("rst_rd2", rd2A, 32'h0);
    check("rst_busy", busyA, 32'h0);
    check("rst_done", doneA, 32'h0);
    #2 reset = 1'b1;

    // Every address reads zero after reset.
    for (int a = 0; a < 8; a++) begin
      raddr1 = 3'(a);
      raddr2 = 3'(7 - a);
      step();
      check($sformatf("init_rd1_a%0d", a), rd1A, 32'h0);
      check($sformatf("init_rd2_a%0d", 7 - a), rd2A, 32'h0);
    end
    check("init_busy", busyA, 32'h0);

    // Write then read on both ports one cycle later.
    writeReg(3'd3, 32'hDEAD_BEEF);
    raddr1 = 3'd3;
    raddr2 = 3'd3;
    step();
    check("wr3_rd1", rd1A, 32'hDEAD_BEEF);
    check("wr3_rd2", rd2A, 32'hDEAD_BEEF);
    check("wr3_rd1_nz", rd1B, 32'hDEAD_BEEF);

    // Same-edge write/read returns the new data.
    raddr1 = 3'd5;
    writeReg(3'd5, 32'h1234_5678);
    check("byp5_rd1", rd1A, 32'h1234_5678);
    check("byp5_rd2_keep", rd2A, 32'hDEAD_BEEF);

    // Entry 0: hardwired zero versus ordinary storage.
    raddr1 = 3'd0;
    writeReg(3'd0, 32'hFFFF_FFFF);
    check("z0_byp_zero", rd1A, 32'h0);
    check("z0_byp_nz", rd1B, 32'hFFFF_FFFF);
    step();
    check("z0_rd_zero", rd1A, 32'h0);
    check("z0_rd_nz", rd1B, 32'hFFFF_FFFF);
    check("z0_rd_d5", rd1C, 32'h0);

    // Addresses beyond DEPTH=5 ignore writes and read zero.
    raddr1 = 3'd6;
    writeReg(3'd6, 32'h0000_0066);
    check("a6_byp_d8", rd1A, 32'h0000_0066);
    check("a6_byp_d5", rd1C, 32'h0);
    step();
    check("a6_rd_d5", rd1C, 32'h0);
    raddr1 = 3'd4;
    writeReg(3'd4, 32'h0000_0044);
    check("a4_byp_d5", rd1C, 32'h0000_0044);

    // Fill with i+1 then sweep; writes to entry 7 during the sweep are dropped.
    for (int i = 0; i < 8; i++) writeReg(3'(i), 32'(i + 1));
    raddr1 = 3'd7;
    clrReq = 1'b1;
    step();
    clrReq = 1'b0;
    check("sw_start_busy", busyA, 32'h1);
    check("sw_start_done", doneA, 32'h0);
    check("sw_start_rd7", rd1A, 32'h8);
    for (int j = 1; j <= 8; j++) begin
      we     = 1'b1;
      waddr  = 3'd7;
      wdata  = 32'h0000_00AA;
      raddr1 = 3'd7;
      raddr2 = 3'(j - 1);
      step();
      check($sformatf("sw%0d_busy", j), busyA, (j < 8) ? 32'h1 : 32'h0);
      check($sformatf("sw%0d_done", j), doneA, (j == 8) ? 32'h1 : 32'h0);
      check($sformatf("sw%0d_rd7", j), rd1A, (j < 8) ? 32'h8 : 32'h0);
      check($sformatf("sw%0d_clrbyp", j), rd2A, 32'h0);
      check($sformatf("sw%0d_busy_d5", j), busyC, (j <= 4) ? 32'h1 : 32'h0);
      check($sformatf("sw%0d_done_d5", j), doneC, (j == 5) ? 32'h1 : 32'h0);
    end
    we = 1'b0;
    step();
    check("sw_after_done", doneA, 32'h0);
    check("sw_after_busy", busyA, 32'h0);
    for (int a = 0; a < 8; a++) begin
      raddr1 = 3'(a);
      raddr2 = 3'(a);
      step();
      check($sformatf("post_rd1_a%0d", a), rd1A, 32'h0);
      check($sformatf("post_rd_nz_a%0d", a), rd1B, 32'h0);
    end

    // Reset in the middle of a sweep aborts it without a done pulse.
    writeReg(3'd2, 32'h0000_0022);
    raddr1 = 3'd2;
    clrReq = 1'b1;
    step();
    clrReq = 1'b0;
    step();
    step();
    check("mid_rd2_before", rd1A, 32'h0000_0022);
    check("mid_busy_before", busyA, 32'h1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_rd1", rd1A, 32'h0);
    check("mid_rst_rd2", rd2A, 32'h0);
    check("mid_rst_busy", busyA, 32'h0);
    check("mid_rst_done", doneA, 32'h0);
    step();
    step();
    check("mid_rst_no_done", doneA, 32'h0);
    #2 reset = 1'b1;
    step();
    check("mid_after_rd2", rd1A, 32'h0);
    check("mid_after_busy", busyA, 32'h0);
    check("mid_after_done", doneA, 32'h0);

    // Request held high restarts one edge after the completion edge.
    clrReq = 1'b1;
    step();
    check("hold_busy_k", busyA, 32'h1);
    repeat (7) step();
    check("hold_busy_k7", busyA, 32'h1);
    step();
    check("hold_done_k8", doneA, 32'h1);
    check("hold_busy_k8", busyA, 32'h0);
    step();
    check("hold_busy_k9", busyA, 32'h1);
    check("hold_done_k9", doneA, 32'h0);
    clrReq = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
